// File: rtl/aes_pkg.sv
// AES-128 key-schedule types, constants and GF(2^8) helpers.
// Shared by the sequencer, its interface and the round expander.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    typedef logic [KEY_W-1:0] round_key_t;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_READY
    } ks_state_t;

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 by repeated squaring, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] v;
        sq = a;
        v  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            v  = gf_mul(v, sq);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
                 ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_schedule_seq_if.sv
// Key-load handshake, round-key read port and status of the
// key-schedule sequencer.
interface key_schedule_seq_if #(
    parameter int KEY_W = 128
);
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] user_key;
    logic             flush;
    logic [3:0]       rd_idx;
    logic [KEY_W-1:0] rd_key;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             keys_valid;

    modport master (
        output key_valid, user_key, flush, rd_idx,
        input  key_ready, rd_key, rd_valid,
        input  busy, done, keys_valid
    );

    modport slave (
        input  key_valid, user_key, flush, rd_idx,
        output key_ready, rd_key, rd_valid,
        output busy, done, keys_valid
    );

endinterface

// File: rtl/expand_single_round.sv
// One AES-128 key-expansion step: round key r-1 -> round key r.
// Purely combinational.
module expand_single_round
    import aes_pkg::*;
(
    input  logic [3:0] round_no,
    input  round_key_t before_ex,
    output round_key_t after_ex
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = before_ex;

    // SubWord(RotWord(w3)) xor Rcon
    assign t = {sbox(w3[23:16]) ^ rcon(round_no),
                sbox(w3[15:8]),
                sbox(w3[7:0]),
                sbox(w3[31:24])};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign after_ex = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_seq.sv
// Iterative AES-128 key schedule: one expander reused over NR cycles,
// round keys 0..NR held in a register file with a combinational read.
module key_schedule_seq #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input logic               clk,
    input logic               rst_n,
    key_schedule_seq_if.slave ks
);
    import aes_pkg::*;

    if (NR != 10 || KEY_W != 128) begin : g_cfg_check
        $error("key_schedule_seq: only AES-128 supported");
    end

    ks_state_t  state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic       kv_q, kv_d;
    logic       done_q, done_d;
    logic       key_ready, busy, accept;
    logic       wr_en;
    logic [3:0] wr_idx;
    round_key_t wr_data;
    round_key_t before_ex, after_ex, rd_mux;
    round_key_t rk_q [0:NR];

    assign key_ready = (state_q != KS_EXPAND);
    assign busy      = (state_q == KS_EXPAND);
    assign accept    = ks.key_valid && key_ready && !ks.flush;

    assign ks.key_ready  = key_ready;
    assign ks.busy       = busy;
    assign ks.keys_valid = kv_q;
    assign ks.done       = done_q;
    assign ks.rd_key     = rd_mux;
    assign ks.rd_valid   = (ks.rd_idx <= 4'(NR))
                        && (kv_q || (busy && ks.rd_idx < rnd_q));

    expand_single_round u_round (
        .round_no  (rnd_q),
        .before_ex (before_ex),
        .after_ex  (after_ex)
    );

    always_comb begin
        before_ex = '0;
        rd_mux    = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rnd_q - 4'd1 == 4'(i)) before_ex = rk_q[i];
            if (ks.rd_idx == 4'(i))    rd_mux    = rk_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        kv_d    = kv_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = rnd_q;
        wr_data = after_ex;
        unique case (1'b1)
            ks.flush: begin
                state_d = KS_IDLE;
                rnd_d   = 4'd0;
                kv_d    = 1'b0;
            end
            accept: begin
                wr_en   = 1'b1;
                wr_idx  = 4'd0;
                wr_data = ks.user_key;
                rnd_d   = 4'd1;
                kv_d    = 1'b0;
                state_d = KS_EXPAND;
            end
            (busy && !ks.flush): begin
                wr_en = 1'b1;
                rnd_d = rnd_q + 4'd1;
                // last write: rnd parks at NR+1 until the next accept
                if (rnd_q == 4'(NR)) begin
                    state_d = KS_READY;
                    kv_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KS_IDLE;
            rnd_q   <= 4'd0;
            kv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            kv_q    <= kv_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i <= NR; i++) begin
                if (wr_idx == 4'(i)) rk_q[i] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: known-answer table, corner-case sequences
// and random keys against a word-level FIPS-197 key expansion model.
module tb_key_schedule_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_schedule_seq_if ks ();

    key_schedule_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks)
    );

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_ZERO = 128'h0;
    localparam logic [127:0] F_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] F_RK3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] F_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] S_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         vld;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [0:7];

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] mk [0:10];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic rd(input logic [3:0] i, output logic [127:0] k,
                      output logic v);
        ks.rd_idx = i;
        #1;
        k = ks.rd_key;
        v = ks.rd_valid;
    endtask

    // Called at the negedge after the accept edge; expects done after E10.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!ks.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done latency"}, 128'(n), 128'd10);
        chk({tag, " keys_valid"}, 128'(ks.keys_valid), 128'd1);
        @(negedge clk);
        chk({tag, " done one cycle"}, 128'(ks.done), 128'd0);
    endtask

    task automatic load_key(input logic [127:0] k, input string tag);
        @(negedge clk);
        ks.key_valid = 1'b1;
        ks.user_key  = k;
        @(negedge clk);
        ks.key_valid = 1'b0;
        chk({tag, " busy"}, 128'(ks.busy), 128'd1);
        wait_done(tag);
    endtask

    initial begin
        logic [127:0] k, key;
        logic         v;
        int           dp;

        ks.key_valid = 1'b0;
        ks.user_key  = '0;
        ks.flush     = 1'b0;
        ks.rd_idx    = 4'd0;
        build_sbox();

        vt[0] = '{K_FIPS, 4'd1,  1'b1, F_RK1};
        vt[1] = '{K_FIPS, 4'd3,  1'b1, F_RK3};
        vt[2] = '{K_FIPS, 4'd10, 1'b1, F_RK10};
        vt[3] = '{K_FIPS, 4'd0,  1'b1, K_FIPS};
        vt[4] = '{K_SEQ,  4'd10, 1'b1, S_RK10};
        vt[5] = '{K_ZERO, 4'd10, 1'b1, Z_RK10};
        vt[6] = '{K_ZERO, 4'd11, 1'b0, 128'h0};
        vt[7] = '{K_ZERO, 4'd15, 1'b0, 128'h0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst key_ready", 128'(ks.key_ready), 128'd1);
        chk("rst busy", 128'(ks.busy), 128'd0);
        chk("rst done", 128'(ks.done), 128'd0);
        chk("rst keys_valid", 128'(ks.keys_valid), 128'd0);
        rd(4'd0, k, v);
        chk("rst rd_key", k, 128'h0);
        chk("rst rd_valid", 128'(v), 128'd0);

        for (int i = 0; i < 8; i++) begin
            if (i == 0 || vt[i].key != vt[i-1].key)
                load_key(vt[i].key, $sformatf("vec%0d", i));
            rd(vt[i].idx, k, v);
            chk($sformatf("vec%0d rd_key", i), k, vt[i].exp);
            chk($sformatf("vec%0d rd_valid", i), 128'(v), 128'(vt[i].vld));
        end

        // early read of rk[3] while expanding
        ks.rd_idx = 4'd3;
        @(negedge clk);
        ks.key_valid = 1'b1;
        ks.user_key  = K_FIPS;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            ks.key_valid = 1'b0;
            rd(4'd3, k, v);
            chk($sformatf("early E%0d rd_valid", e), 128'(v),
                128'(e >= 3));
            if (e >= 3) chk($sformatf("early E%0d rd_key", e), k, F_RK3);
        end
        @(negedge clk);
        chk("early done", 128'(ks.done), 128'd1);
        @(negedge clk);

        // offer a different key mid-expansion: must be ignored
        ks.key_valid = 1'b1;
        ks.user_key  = K_FIPS;
        @(negedge clk);
        ks.user_key = K_SEQ;
        for (int e = 0; e < 6; e++) begin
            chk($sformatf("ign E%0d key_ready", e), 128'(ks.key_ready),
                128'd0);
            if (e < 5) @(negedge clk);
        end
        ks.key_valid = 1'b0;
        dp = 0;
        while (!ks.done && dp < 30) begin
            @(negedge clk);
            dp++;
            if (!ks.done)
                chk("ign key_ready", 128'(ks.key_ready), 128'd0);
        end
        chk("ign done latency", 128'(dp), 128'd5);
        rd(4'd10, k, v);
        chk("ign rk10", k, F_RK10);
        @(negedge clk);

        // flush at E5 together with key_valid
        ks.key_valid = 1'b1;
        ks.user_key  = K_FIPS;
        @(negedge clk);
        ks.key_valid = 1'b0;
        repeat (4) @(negedge clk);
        ks.flush     = 1'b1;
        ks.key_valid = 1'b1;
        ks.user_key  = K_SEQ;
        @(negedge clk);
        ks.flush     = 1'b0;
        ks.key_valid = 1'b0;
        chk("flush busy", 128'(ks.busy), 128'd0);
        chk("flush key_ready", 128'(ks.key_ready), 128'd1);
        chk("flush keys_valid", 128'(ks.keys_valid), 128'd0);
        chk("flush done", 128'(ks.done), 128'd0);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), k, v);
            chk($sformatf("flush rd_valid%0d", i), 128'(v), 128'd0);
        end
        dp = 0;
        repeat (15) begin
            @(negedge clk);
            if (ks.done || ks.busy) dp++;
        end
        chk("flush no activity", 128'(dp), 128'd0);

        // async reset in the middle of expansion
        ks.key_valid = 1'b1;
        ks.user_key  = K_FIPS;
        @(negedge clk);
        ks.key_valid = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 128'(ks.busy), 128'd0);
        chk("arst keys_valid", 128'(ks.keys_valid), 128'd0);
        chk("arst done", 128'(ks.done), 128'd0);
        chk("arst key_ready", 128'(ks.key_ready), 128'd1);
        rd(4'd0, k, v);
        chk("arst rd_key0", k, 128'h0);
        chk("arst rd_valid0", 128'(v), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_key(K_SEQ, "post-rst");
        rd(4'd10, k, v);
        chk("post-rst rk10", k, S_RK10);

        // re-key from READY with the all-zero key
        @(negedge clk);
        ks.key_valid = 1'b1;
        ks.user_key  = K_ZERO;
        @(posedge clk);
        #1;
        chk("rekey keys_valid drop", 128'(ks.keys_valid), 128'd0);
        chk("rekey busy", 128'(ks.busy), 128'd1);
        @(negedge clk);
        ks.key_valid = 1'b0;
        wait_done("rekey");
        rd(4'd10, k, v);
        chk("rekey rk10", k, Z_RK10);
        rd(4'd11, k, v);
        chk("rekey rd11 key", k, 128'h0);
        chk("rekey rd11 valid", 128'(v), 128'd0);

        // random keys against the reference expansion
        for (int r = 0; r < 6; r++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            ref_expand(key);
            load_key(key, $sformatf("rnd%0d", r));
            for (int i = 0; i <= 10; i++) begin
                rd(4'(i), k, v);
                chk($sformatf("rnd%0d rk%0d", r, i), k, mk[i]);
                chk($sformatf("rnd%0d rv%0d", r, i), 128'(v), 128'd1);
            end
            rd(4'($urandom_range(11, 15)), k, v);
            chk($sformatf("rnd%0d oob", r), {k[126:0], v}, 128'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
